// File: rtl/mult_div.sv
// -----------------------------------------------------------------------------
// mult_div
//   Sequential sign-magnitude restoring divider, the inverse of the mult block.
//   Divides an (M_bits+N_bits)-bit product-format dividend by an N_bits divisor
//   and produces one quotient bit per clock, using the same start/busy/done
//   handshake as mult so that mult's product can be fed straight back in.
//
// Ports
//   clk    in   1              rising-edge clock
//   rst    in   1              synchronous, active-high reset
//   start  in   1              request, accepted in IDLE or DONE
//   dvd    in   M_bits+N_bits  dividend, sign-magnitude, MSB = sign
//   dvs    in   N_bits         divisor, sign-magnitude, MSB = sign
//   quo    out  M_bits         quotient, sign-magnitude
//   rem    out  N_bits         remainder, sign-magnitude (takes dividend sign)
//   busy   out  1              operation in progress (CHECK / ITER)
//   done   out  1              one-cycle completion pulse
//   ovf    out  1              quotient magnitude does not fit M_bits-1 bits
//   dbz    out  1              divisor magnitude is zero
// -----------------------------------------------------------------------------
module mult_div #(
  parameter int M_bits = 12,
  parameter int N_bits = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [M_bits+N_bits-1:0] dvd,
  input  logic [N_bits-1:0]        dvs,
  output logic [M_bits-1:0]        quo,
  output logic [N_bits-1:0]        rem,
  output logic                     busy,
  output logic                     done,
  output logic                     ovf,
  output logic                     dbz
);

  localparam int W  = M_bits + N_bits;
  localparam int CW = $clog2(M_bits);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_ITER,
    S_DONE
  } state_e;

  state_e              state_q;
  logic [W-1:0]        dvd_q;
  logic [N_bits-1:0]   dvs_q;
  logic [N_bits-2:0]   p_q;      // partial remainder, always < B
  logic [M_bits-2:0]   q_q;      // dividend low bits shifting out, quotient bits shifting in
  logic [CW-1:0]       cnt_q;
  logic [M_bits-1:0]   quo_q;
  logic [N_bits-1:0]   rem_q;
  logic                busy_q;
  logic                done_q;
  logic                ovf_q;
  logic                dbz_q;

  // Operand magnitudes taken from the latched copies.
  logic [W-2:0]        a_mag;
  logic [N_bits-2:0]   b_mag;
  logic [N_bits-1:0]   b_ext;
  logic [N_bits-1:0]   a_hi;
  logic                b_zero;
  logic                too_big;

  assign a_mag   = dvd_q[W-2:0];
  assign b_mag   = dvs_q[N_bits-2:0];
  assign b_ext   = {1'b0, b_mag};
  // The top N bits of A are what the first M-1 quotient bits are divided from;
  // if they already reach B the quotient needs more than M-1 bits.
  assign a_hi    = a_mag[W-2:M_bits-1];
  assign b_zero  = (b_mag == '0);
  assign too_big = (a_hi >= b_ext);

  // One restoring step: shift the next dividend bit into the partial remainder
  // and subtract B when it fits.
  logic [N_bits-1:0]   p_sh;
  logic [N_bits-1:0]   p_sub;
  logic                fits;
  logic [N_bits-2:0]   p_d;
  logic [M_bits-2:0]   q_d;
  logic                sq_d;
  logic                sr_d;

  assign p_sh  = {p_q, q_q[M_bits-2]};
  assign fits  = (p_sh >= b_ext);
  assign p_sub = p_sh - b_ext;
  assign p_d   = fits ? p_sub[N_bits-2:0] : p_sh[N_bits-2:0];
  assign q_d   = {q_q[M_bits-3:0], fits};
  // Signs are suppressed on zero magnitudes so no negative zero is produced.
  assign sq_d  = (dvd_q[W-1] ^ dvs_q[N_bits-1]) & (|q_d);
  assign sr_d  = dvd_q[W-1] & (|p_d);

  // NOTE: every register below is assigned with <= so all state updates on an
  // edge see the values from before that edge, matching the flop hardware.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      p_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            dvd_q   <= dvd;
            dvs_q   <= dvs;
            busy_q  <= 1'b1;
            state_q <= S_CHECK;
          end else begin
            state_q <= S_IDLE;
          end
        end

        S_CHECK: begin
          if (b_zero || too_big) begin
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= b_zero;
            ovf_q   <= ~b_zero;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            p_q     <= a_hi[N_bits-2:0];
            q_q     <= a_mag[M_bits-2:0];
            cnt_q   <= CW'(M_bits - 1);
            state_q <= S_ITER;
          end
        end

        S_ITER: begin
          p_q   <= p_d;
          q_q   <= q_d;
          cnt_q <= cnt_q - 1'b1;
          // Last of the M-1 steps: publish the result on the edge entering DONE.
          if (cnt_q == CW'(1)) begin
            quo_q   <= {sq_d, q_d};
            rem_q   <= {sr_d, p_d};
            ovf_q   <= 1'b0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign quo  = quo_q;
  assign rem  = rem_q;
  assign busy = busy_q;
  assign done = done_q;
  assign ovf  = ovf_q;
  assign dbz  = dbz_q;

endmodule

// File: tb/tb_mult_div.sv
// -----------------------------------------------------------------------------
// tb_mult_div
//   Self-checking bench for mult_div. Expected results come from integer
//   division of the operand magnitudes plus the sign rules; directed cases
//   cover the documented examples, then randomized operands follow.
// -----------------------------------------------------------------------------
module tb_mult_div;

  localparam int M = 12;
  localparam int N = 8;
  localparam int W = M + N;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  dvd = '0;
  logic [N-1:0]  dvs = '0;
  logic [M-1:0]  quo;
  logic [N-1:0]  rem;
  logic          busy;
  logic          done;
  logic          ovf;
  logic          dbz;

  int n_checks = 0;
  int n_fail   = 0;

  logic [M-1:0] exp_quo;
  logic [N-1:0] exp_rem;
  logic         exp_ovf;
  logic         exp_dbz;

  mult_div #(.M_bits(M), .N_bits(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .dvd   (dvd),
    .dvs   (dvs),
    .quo   (quo),
    .rem   (rem),
    .busy  (busy),
    .done  (done),
    .ovf   (ovf),
    .dbz   (dbz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: plain integer division of magnitudes, signs applied afterwards.
  task automatic model(input logic [W-1:0] d, input logic [N-1:0] s);
    logic [31:0] a, b, qq, rr;
    a = 32'(d[W-2:0]);
    b = 32'(s[N-2:0]);
    exp_quo = '0;
    exp_rem = '0;
    exp_ovf = 1'b0;
    exp_dbz = 1'b0;
    if (b == 0) begin
      exp_dbz = 1'b1;
    end else begin
      qq = a / b;
      rr = a % b;
      if (qq >= (32'd1 << (M - 1))) begin
        exp_ovf = 1'b1;
      end else begin
        exp_quo = {(d[W-1] ^ s[N-1]) && (qq != 0), qq[M-2:0]};
        exp_rem = {d[W-1] && (rr != 0), rr[N-2:0]};
      end
    end
  endtask

  // Present a request so that the next rising edge samples it.
  task automatic launch(input logic [W-1:0] d, input logic [N-1:0] s);
    @(negedge clk);
    dvd   = d;
    dvs   = s;
    start = 1'b1;
  endtask

  // Wait for the edge that accepts the pending request, scramble the inputs,
  // then follow the operation to done and compare latency and results.
  task automatic finish_op(input logic [W-1:0] d, input logic [N-1:0] s,
                           input bit interfere, input string tag);
    int n;
    int lat;
    bit seen;
    model(d, s);
    lat = (exp_ovf || exp_dbz) ? 1 : M;
    @(posedge clk);
    #1;
    start = 1'b0;
    dvd   = W'($urandom);
    dvs   = N'($urandom);
    check({tag, "_busy_start"}, 32'(busy), 32'd1);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (done) begin
        seen = 1'b1;
      end else if (interfere && n == 3) begin
        start = 1'b1;
        dvd   = W'($urandom);
        dvs   = N'($urandom_range(1, 127));
      end else if (interfere && n == 4) begin
        start = 1'b0;
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(n), 32'(lat));
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
    check({tag, "_quo"}, 32'(quo), 32'(exp_quo));
    check({tag, "_rem"}, 32'(rem), 32'(exp_rem));
    check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
    check({tag, "_dbz"}, 32'(dbz), 32'(exp_dbz));
  endtask

  // One cycle after done with no new start: pulse over, results held.
  task automatic hold_check(input string tag);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_quo_hold"}, 32'(quo), 32'(exp_quo));
    check({tag, "_rem_hold"}, 32'(rem), 32'(exp_rem));
  endtask

  task automatic run(input logic [W-1:0] d, input logic [N-1:0] s, input string tag);
    launch(d, s);
    finish_op(d, s, 1'b0, tag);
    hold_check(tag);
  endtask

  initial begin
    logic [W-1:0] rd;
    logic [N-1:0] rs;
    int b;
    int cnt_done;

    // Reset, with start asserted to show reset wins.
    start = 1'b1;
    dvd   = 20'h04000;
    dvs   = 8'h40;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quo", 32'(quo), 32'd0);
    check("rst_rem", 32'(rem), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_dbz", 32'(dbz), 32'd0);
    start = 1'b0;
    rst   = 1'b0;

    // Directed examples.
    run(20'h04000, 8'h40, "inv");
    check("inv_quo_lit", 32'(quo), 32'h100);
    run(20'h84000, 8'h40, "neg_dvd");
    check("neg_dvd_quo_lit", 32'(quo), 32'h900);
    run(20'h00007, 8'h83, "neg_dvs");
    check("neg_dvs_quo_lit", 32'(quo), 32'h802);
    check("neg_dvs_rem_lit", 32'(rem), 32'h01);
    run(20'h12345, 8'h80, "dbz_neg0");
    check("dbz_flag_lit", 32'(dbz), 32'd1);
    run(20'h7FFFF, 8'h01, "ovf");
    check("ovf_flag_lit", 32'(ovf), 32'd1);
    run(20'h80002, 8'h05, "negzero");
    check("negzero_quo_lit", 32'(quo), 32'h000);
    check("negzero_rem_lit", 32'(rem), 32'h82);

    // start during ITER must be ignored.
    launch(20'h04000, 8'h40);
    finish_op(20'h04000, 8'h40, 1'b1, "ignore");
    hold_check("ignore");

    // Back-to-back: new start in the DONE cycle.
    launch(20'h00007, 8'h83);
    finish_op(20'h00007, 8'h83, 1'b0, "b2b_a");
    dvd   = 20'h04000;
    dvs   = 8'h40;
    start = 1'b1;
    finish_op(20'h04000, 8'h40, 1'b0, "b2b_b");
    hold_check("b2b_b");

    // Reset in the middle of ITER aborts with no trace at the outputs.
    launch(20'h04000, 8'h40);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_quo", 32'(quo), 32'd0);
    check("abort_rem", 32'(rem), 32'd0);
    check("abort_ovf", 32'(ovf), 32'd0);
    check("abort_dbz", 32'(dbz), 32'd0);
    cnt_done = 0;
    repeat (16) begin
      @(posedge clk);
      #1;
      if (done) cnt_done++;
    end
    check("abort_no_done", 32'(cnt_done), 32'd0);
    run(20'h04000, 8'h40, "after_abort");

    // Randomized operands, mostly in range with some overflow and zero divisors.
    for (int i = 0; i < 40; i++) begin
      b = $urandom_range(0, 127);
      if (i % 10 == 9) b = 0;
      if (b == 0 || $urandom_range(0, 3) == 0)
        rd = W'($urandom);
      else
        rd = {1'b0, 19'($urandom_range(0, b * 2048 - 1))};
      rd[W-1] = 1'($urandom);
      rs = {1'($urandom), 7'(b)};
      run(rd, rs, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
